// File: rtl/pixel_row_packer_if.sv
// Pixel-stream and row-write bus between the capture front end, the packer and the row-register bank.
interface pixel_row_packer_if #(
   parameter int unsigned WordBits = 28,
   parameter int unsigned AddrBits = 5
) ();
   logic                pix_valid;
   logic                pix_data;
   logic                pix_ready;
   logic                wr_en;
   logic [AddrBits-1:0] wr_addr;
   logic [WordBits-1:0] wr_data;

   // Source side: drives pixels, observes the packer's ready and row writes.
   modport master (
      output pix_valid, pix_data,
      input  pix_ready, wr_en, wr_addr, wr_data
   );

   // Packer side.
   modport slave (
      input  pix_valid, pix_data,
      output pix_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/pixel_row_packer.sv
// Packs a serial 1-bit pixel stream into WordBits-wide row words and writes them,
// one strobe per row, into the row-register bank.
module pixel_row_packer #(
   parameter int unsigned WordBits  = 28,
   parameter int unsigned NrOfWords = 28,
   parameter int unsigned AddrBits  = 5    // 2**AddrBits must cover NrOfWords
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Tick,
   input  logic               start,
   input  logic               abort,
   pixel_row_packer_if.slave  bus,
   output logic               busy,
   output logic               done
);

   localparam int unsigned         CntBits  = (WordBits > 2) ? $clog2(WordBits) : 1;
   localparam logic [CntBits-1:0]  LastPix  = CntBits'(WordBits - 1);
   localparam logic [AddrBits-1:0] LastRow  = AddrBits'(NrOfWords - 1);

   typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

   state_t              state, state_next;
   logic [WordBits-1:0] shift_q;
   logic [WordBits-1:0] shift_next;
   logic [CntBits-1:0]  count_q;
   logic [AddrBits-1:0] row_q;
   logic [AddrBits-1:0] wr_addr_q;
   logic [WordBits-1:0] wr_data_q;
   logic                pix_ready_q, busy_q, done_q;
   logic                pix_ready_d, busy_d, done_d;
   logic                wr_en_c;
   logic                accept;
   logic                row_full;

   // abort outranks a pixel arriving in the same Tick cycle
   assign accept     = Tick & ~abort & pix_ready_q & bus.pix_valid;
   assign row_full   = (count_q == LastPix);
   assign shift_next = {shift_q[WordBits-2:0], bus.pix_data};

   // State and status flags
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         pix_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state       <= state_next;
         pix_ready_q <= pix_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next state; nothing moves without Tick
   always_comb begin
      state_next = state;
      if (Tick) begin
         if (abort) begin
            state_next = IDLE;
         end else begin
            case (state)
               IDLE:  if (start) state_next = FILL;
               FILL:  if (accept && row_full) state_next = WRITE;
               WRITE: state_next = (row_q == LastRow) ? DONE : FILL;
               DONE:  if (start) state_next = FILL;
               default: state_next = IDLE;
            endcase
         end
      end
   end

   // Flags are precomputed from the next state so they leave a flop
   always_comb begin
      pix_ready_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      wr_en_c     = 1'b0;
      pix_ready_d = (state_next == FILL);
      busy_d      = (state_next == FILL) || (state_next == WRITE);
      done_d      = (state_next == DONE);
      // Strobe shares the registers' clock enable, so it must follow Tick directly
      wr_en_c     = Tick & ~abort & (state == WRITE);
   end

   // Shift register, pixel/row counters and the registered write bus
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         shift_q   <= '0;
         count_q   <= '0;
         row_q     <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else if (Tick) begin
         if (abort) begin
            shift_q <= '0;
            count_q <= '0;
            row_q   <= '0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (start) begin
                     shift_q <= '0;
                     count_q <= '0;
                     row_q   <= '0;
                  end
               end
               FILL: begin
                  if (accept) begin
                     shift_q <= shift_next;
                     if (row_full) begin
                        count_q   <= '0;
                        wr_data_q <= shift_next;
                        wr_addr_q <= row_q;
                     end else begin
                        count_q <= count_q + CntBits'(1);
                     end
                  end
               end
               WRITE: begin
                  if (row_q != LastRow) row_q <= row_q + AddrBits'(1);
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.pix_ready = pix_ready_q;
   assign bus.wr_en     = wr_en_c;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule
